// File: rtl/alarm_clock_multi_pkg.sv
// Shared types and constants for the multi-alarm clock core.
package alarm_clk_pkg;

    typedef struct packed {
        logic [4:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
    } time_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } ring_state_t;

    localparam logic [4:0] MAX_HH = 5'd23;
    localparam logic [5:0] MAX_MM = 6'd59;
    localparam logic [5:0] MAX_SS = 6'd59;

    function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max_v);
        return (v >= max_v) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc_hh(input logic [4:0] v);
        return (v >= MAX_HH) ? 5'd0 : v + 5'd1;
    endfunction

endpackage

// File: rtl/alarm_clock_multi_if.sv
// Button/enable inputs and display/alarm outputs of the alarm clock core.
interface alarm_clock_multi_if #(
    parameter int N_ALARMS = 4
) ();
    localparam int SEL_W = $clog2(N_ALARMS + 1);
    localparam int ID_W  = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;

    logic [SEL_W-1:0]    sel;
    logic                inc_hr;
    logic                inc_min;
    logic                snooze;
    logic [N_ALARMS-1:0] alarm_en;
    logic                alarm;
    logic [ID_W-1:0]     alarm_id;
    logic                sec_tick;
    logic [16:0]         disp_time;

    modport master (
        output sel, inc_hr, inc_min, snooze, alarm_en,
        input  alarm, alarm_id, sec_tick, disp_time
    );

    modport slave (
        input  sel, inc_hr, inc_min, snooze, alarm_en,
        output alarm, alarm_id, sec_tick, disp_time
    );
endinterface

// File: rtl/alarm_clock_multi_tick_gen.sv
// Seconds prescaler: tick_due_o flags the terminal count, sec_tick_o pulses the cycle after.
module tick_gen #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic tick_due_o,
    output logic sec_tick_o
);
    localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

    logic [CW-1:0] cnt_q;
    logic          sec_tick_q;

    assign tick_due_o = (cnt_q == LAST);
    assign sec_tick_o = sec_tick_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            sec_tick_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q      <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            cnt_q      <= tick_due_o ? '0 : cnt_q + 1'b1;
            sec_tick_q <= tick_due_o;
        end
    end
endmodule

// File: rtl/alarm_clock_multi.sv
// 24 h clock with N settable alarms and a ring/snooze controller.
// Optional build macro ALARM_AUTOSNOOZE_EN: ring timeout re-enters snooze instead of idle.
module alarm_clock_multi
    import alarm_clk_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int N_ALARMS   = 4,
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic              clk,
    input  logic              reset,
    alarm_clock_multi_if.slave bus
);
    localparam int ID_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
    localparam int RC_W = $clog2(RING_SECS + 1);
    localparam int SZ_W = $clog2(SNOOZE_MIN * 60 + 1);
    localparam logic [RC_W-1:0] RING_LAST = RC_W'(RING_SECS - 1);
    localparam logic [SZ_W-1:0] SNZ_LOAD  = SZ_W'(SNOOZE_MIN * 60);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_RINGING = RINGING;
    localparam logic [1:0] S_SNOOZED = SNOOZED;

    logic hr_prev_q, min_prev_q, snz_prev_q;
    logic hr_edge, min_edge, snz_edge;
    logic sel_clk, clk_edit;
    logic tick_due, sec_tick;
    logic [N_ALARMS-1:0] alm_wr;

    time_t time_q, time_d;
    time_t disp_q, disp_d;
    logic [4:0] alm_hh_q [N_ALARMS];
    logic [5:0] alm_mm_q [N_ALARMS];

    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [RC_W-1:0] ring_q, ring_d;
    logic [SZ_W-1:0] snz_q, snz_d;
    logic            match;
    logic [ID_W-1:0] match_id;
    logic            en_cur;

    assign hr_edge  = bus.inc_hr  & ~hr_prev_q;
    assign min_edge = bus.inc_min & ~min_prev_q;
    assign snz_edge = bus.snooze  & ~snz_prev_q;
    assign sel_clk  = (bus.sel == '0);
    assign clk_edit = sel_clk & (hr_edge | min_edge);

    tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (clk_edit),
        .tick_due_o (tick_due),
        .sec_tick_o (sec_tick)
    );

    // An edit wins over a tick due in the same cycle; the prescaler restarts too.
    always_comb begin
        time_d = time_q;
        if (clk_edit) begin
            if (hr_edge)  time_d.hh = inc_hh(time_q.hh);
            if (min_edge) time_d.mm = inc_wrap(time_q.mm, MAX_MM);
            time_d.ss = 6'd0;
        end else if (tick_due) begin
            time_d.ss = inc_wrap(time_q.ss, MAX_SS);
            if (time_q.ss == MAX_SS) begin
                time_d.mm = inc_wrap(time_q.mm, MAX_MM);
                if (time_q.mm == MAX_MM) time_d.hh = inc_hh(time_q.hh);
            end
        end
    end

    always_comb begin
        alm_wr = '0;
        disp_d = time_q;
        for (int k = 0; k < N_ALARMS; k++) begin
            if (int'(bus.sel) == k + 1) begin
                alm_wr[k] = 1'b1;
                disp_d    = '{hh: alm_hh_q[k], mm: alm_mm_q[k], ss: 6'd0};
            end
        end
    end

    // Descending scan so the lowest matching index is the one kept.
    always_comb begin
        match    = 1'b0;
        match_id = '0;
        if (sec_tick && time_q.ss == 6'd0) begin
            for (int k = N_ALARMS - 1; k >= 0; k--) begin
                if (bus.alarm_en[k] && alm_hh_q[k] == time_q.hh && alm_mm_q[k] == time_q.mm) begin
                    match    = 1'b1;
                    match_id = ID_W'(k);
                end
            end
        end
    end

    assign en_cur = bus.alarm_en[id_q];

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        case (state_q)
            S_IDLE: begin
                if (match) begin
                    state_d = S_RINGING;
                    id_d    = match_id;
                    ring_d  = '0;
                end
            end
            S_RINGING: begin
                if (!en_cur) begin
                    state_d = S_IDLE;
                end else if (snz_edge) begin
                    state_d = S_SNOOZED;
                    snz_d   = SNZ_LOAD;
                end else if (sec_tick) begin
                    if (ring_q == RING_LAST) begin
`ifdef ALARM_AUTOSNOOZE_EN
                        state_d = S_SNOOZED;
                        snz_d   = SNZ_LOAD;
`else
                        state_d = S_IDLE;
`endif
                    end else begin
                        ring_d = ring_q + 1'b1;
                    end
                end
            end
            S_SNOOZED: begin
                if (!en_cur) begin
                    state_d = S_IDLE;
                end else if (match) begin
                    state_d = S_RINGING;
                    id_d    = match_id;
                    ring_d  = '0;
                end else if (sec_tick) begin
                    if (snz_q <= SZ_W'(1)) begin
                        state_d = S_RINGING;
                        ring_d  = '0;
                    end else begin
                        snz_d = snz_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hr_prev_q  <= 1'b1;
            min_prev_q <= 1'b1;
            snz_prev_q <= 1'b1;
            time_q     <= '0;
            disp_q     <= '0;
            state_q    <= S_IDLE;
            id_q       <= '0;
            ring_q     <= '0;
            snz_q      <= '0;
            for (int k = 0; k < N_ALARMS; k++) begin
                alm_hh_q[k] <= '0;
                alm_mm_q[k] <= '0;
            end
        end else begin
            hr_prev_q  <= bus.inc_hr;
            min_prev_q <= bus.inc_min;
            snz_prev_q <= bus.snooze;
            time_q     <= time_d;
            disp_q     <= disp_d;
            state_q    <= state_d;
            id_q       <= id_d;
            ring_q     <= ring_d;
            snz_q      <= snz_d;
            for (int k = 0; k < N_ALARMS; k++) begin
                if (alm_wr[k]) begin
                    if (hr_edge)  alm_hh_q[k] <= inc_hh(alm_hh_q[k]);
                    if (min_edge) alm_mm_q[k] <= inc_wrap(alm_mm_q[k], MAX_MM);
                end
            end
        end
    end

    assign bus.alarm     = (state_q == S_RINGING);
    assign bus.alarm_id  = id_q;
    assign bus.sec_tick  = sec_tick;
    assign bus.disp_time = disp_q;
endmodule

// File: tb/tb_alarm_clock_multi.sv
// Scoreboard bench for alarm_clock_multi; expected ring behaviour follows ALARM_AUTOSNOOZE_EN.
`timescale 1ns/1ps
module tb_alarm_clock_multi;
    localparam int CLK_FREQ   = 10;
    localparam int N_ALARMS   = 2;
    localparam int RING_SECS  = 3;
    localparam int SNOOZE_MIN = 1;
`ifdef ALARM_AUTOSNOOZE_EN
    localparam logic AUTO = 1'b1;
`else
    localparam logic AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    alarm_clock_multi_if #(.N_ALARMS(N_ALARMS)) bus ();

    alarm_clock_multi #(
        .CLK_FREQ   (CLK_FREQ),
        .N_ALARMS   (N_ALARMS),
        .RING_SECS  (RING_SECS),
        .SNOOZE_MIN (SNOOZE_MIN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [31:0] hms(input int h, input int m, input int s);
        logic [16:0] t;
        t = {5'(h), 6'(m), 6'(s)};
        return 32'(t);
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] act);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk(e.tag, act, e.val);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sb_push("rst_disp", 32'd0);
        sb_push("rst_alarm", 32'd0);
        sb_push("rst_id", 32'd0);
        sb_push("rst_tick", 32'd0);
        sb_pop(32'(bus.disp_time));
        sb_pop(32'(bus.alarm));
        sb_pop(32'(bus.alarm_id));
        sb_pop(32'(bus.sec_tick));
        reset = 1'b0;
    endtask

    // which: 0 = hour, 1 = minute, 2 = snooze
    task automatic press(input int which);
        case (which)
            0:       bus.inc_hr  = 1'b1;
            1:       bus.inc_min = 1'b1;
            default: bus.snooze  = 1'b1;
        endcase
        @(negedge clk);
        bus.inc_hr  = 1'b0;
        bus.inc_min = 1'b0;
        bus.snooze  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.sec_tick !== 1'b1 && n < 2 * CLK_FREQ);
        if (bus.sec_tick !== 1'b1) chk("tick_timeout", 32'(bus.sec_tick), 32'd1);
    endtask

    task automatic run_ticks(input int n, input logic exp_alarm);
        for (int i = 0; i < n; i++) begin
            wait_tick();
            sb_push("alarm_hold", 32'(exp_alarm));
            sb_pop(32'(bus.alarm));
        end
    endtask

    task automatic set_alarm0_and_arm(input logic [1:0] en);
        bus.sel = 2'd1;
        @(negedge clk);
        press(1);
        bus.sel = 2'd0;
        bus.alarm_en = en;
    endtask

    initial begin
        int seen;
        int last_hit;

        bus.sel      = '0;
        bus.inc_hr   = 1'b1;
        bus.inc_min  = 1'b0;
        bus.snooze   = 1'b0;
        bus.alarm_en = '0;
        reset        = 1'b1;
        @(negedge clk);

        // 1: reset state, first second, hour button held through reset
        do_reset();
        seen = 0;
        last_hit = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.sec_tick === 1'b1) begin
                seen++;
                last_hit = i;
            end
        end
        sb_push("t1_tick_count", 32'd1);
        sb_push("t1_tick_cycle", 32'd10);
        sb_pop(32'(seen));
        sb_pop(32'(last_hit));
        @(negedge clk);
        sb_push("t1_disp", hms(0, 0, 1));
        sb_pop(32'(bus.disp_time));

        // 2: set 23:59 by buttons, roll through midnight
        bus.inc_hr = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 23; i++) press(0);
        @(negedge clk);
        sb_push("t2_hr_set", hms(23, 0, 0));
        sb_pop(32'(bus.disp_time));
        for (int i = 0; i < 59; i++) press(1);
        @(negedge clk);
        sb_push("t2_min_set", hms(23, 59, 0));
        sb_pop(32'(bus.disp_time));
        for (int i = 0; i < 59; i++) wait_tick();
        @(negedge clk);
        sb_push("t2_2359_59", hms(23, 59, 59));
        sb_pop(32'(bus.disp_time));
        wait_tick();
        @(negedge clk);
        sb_push("t2_midnight", hms(0, 0, 0));
        sb_push("t2_tick_pulse", 32'd0);
        sb_pop(32'(bus.disp_time));
        sb_pop(32'(bus.sec_tick));

        // 6: out-of-range select ignores edits
        bus.sel = 2'd3;
        press(1);
        press(1);
        @(negedge clk);
        sb_push("t6_disp_clock", hms(0, 0, 0));
        sb_pop(32'(bus.disp_time));
        bus.sel = 2'd1;
        @(negedge clk);
        @(negedge clk);
        sb_push("t6_alarm0_kept", hms(0, 0, 0));
        sb_pop(32'(bus.disp_time));
        bus.sel = 2'd0;

        // 3: alarm0 at 00:01 rings, times out after RING_SECS
        do_reset();
        set_alarm0_and_arm(2'b00);
        bus.sel = 2'd1;
        @(negedge clk);
        @(negedge clk);
        sb_push("t3_alarm_view", hms(0, 1, 0));
        sb_pop(32'(bus.disp_time));
        bus.sel = 2'd0;
        bus.alarm_en = 2'b01;
        run_ticks(60, 1'b0);
        @(negedge clk);
        sb_push("t3_ring", 32'd1);
        sb_push("t3_id", 32'd0);
        sb_push("t3_disp", hms(0, 1, 0));
        sb_pop(32'(bus.alarm));
        sb_pop(32'(bus.alarm_id));
        sb_pop(32'(bus.disp_time));
        run_ticks(RING_SECS, 1'b1);
        @(negedge clk);
        sb_push("t3_timeout", 32'd0);
        sb_pop(32'(bus.alarm));
        run_ticks(SNOOZE_MIN * 60, 1'b0);
        @(negedge clk);
        sb_push("t3_after_timeout", 32'(AUTO));
        sb_pop(32'(bus.alarm));

        // 4: snooze while ringing, ring again after SNOOZE_MIN minutes
        do_reset();
        set_alarm0_and_arm(2'b01);
        run_ticks(60, 1'b0);
        @(negedge clk);
        sb_push("t4_ring", 32'd1);
        sb_pop(32'(bus.alarm));
        run_ticks(1, 1'b1);
        @(negedge clk);
        press(2);
        sb_push("t4_snoozed", 32'd0);
        sb_pop(32'(bus.alarm));
        run_ticks(SNOOZE_MIN * 60, 1'b0);
        @(negedge clk);
        sb_push("t4_reling", 32'd1);
        sb_push("t4_reling_id", 32'd0);
        sb_pop(32'(bus.alarm));
        sb_pop(32'(bus.alarm_id));
        reset = 1'b1;
        @(negedge clk);
        sb_push("t4_reset_alarm", 32'd0);
        sb_push("t4_reset_disp", 32'd0);
        sb_pop(32'(bus.alarm));
        sb_pop(32'(bus.disp_time));

        // 5: two alarms at the same minute, lowest wins, cancel by enable
        do_reset();
        set_alarm0_and_arm(2'b00);
        bus.sel = 2'd2;
        press(1);
        @(negedge clk);
        sb_push("t5_alarm1_view", hms(0, 1, 0));
        sb_pop(32'(bus.disp_time));
        bus.sel = 2'd0;
        bus.alarm_en = 2'b11;
        run_ticks(60, 1'b0);
        @(negedge clk);
        sb_push("t5_ring", 32'd1);
        sb_push("t5_lowest_id", 32'd0);
        sb_pop(32'(bus.alarm));
        sb_pop(32'(bus.alarm_id));
        bus.alarm_en = 2'b10;
        @(negedge clk);
        sb_push("t5_cancel", 32'd0);
        sb_pop(32'(bus.alarm));
        run_ticks(5, 1'b0);
        @(negedge clk);
        sb_push("t5_id_kept", 32'd0);
        sb_pop(32'(bus.alarm_id));

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alarm_clock_multi.md
Name: alarm_clock_multi

Overview:
Parametrised successor to the single-alarm clock core. Keeps one 24 h time-of-day counter and N independently settable alarms. Adds a ring/snooze state machine with a bounded ring duration. Sits between the button debouncers and the display block, and drives the same 17-bit packed time bus and alarm trigger.

Parameters:
CLK_FREQ, 100_000_000, clock cycles per second; sim uses 10.
N_ALARMS, 4, number of alarm registers (1..8).
RING_SECS, 60, seconds the alarm rings before auto-stop.
SNOOZE_MIN, 5, snooze delay in minutes (1..30).

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
sel  in  $clog2(N_ALARMS+1)  0 = clock view/edit; k = alarm k-1.
inc_hr  in  1  debounced level; rising edge increments hours.
inc_min  in  1  debounced level; rising edge increments minutes.
snooze  in  1  debounced level; rising edge snoozes.
alarm_en  in  N_ALARMS  per-alarm enable.
alarm  out  1  high while ringing.
alarm_id  out  max(1,$clog2(N_ALARMS))  index of the ringing/snoozed alarm.
sec_tick  out  1  one-cycle pulse per second.
disp_time  out  17  {hh[16:12], mm[11:6], ss[5:0]}, registered.

Behaviour:
- Reset values: time 00:00:00; all alarms 00:00; prescaler 0; FSM IDLE; alarm=0, alarm_id=0, sec_tick=0, disp_time=0. Edge-detector previous-value registers reset to 1, so a button held through reset produces no edge.
- Prescaler: counts 0..CLK_FREQ-1. sec_tick is high in the cycle after count==CLK_FREQ-1; the time advances in that same cycle.
- Time advance: ss 59→0 carries into mm; mm 59→0 carries into hh; hh 23→0.
- Edits with sel==0:
  - inc_min edge: mm = (mm+1) mod 60, no carry; ss cleared; prescaler cleared.
  - inc_hr edge: hh = (hh+1) mod 24; ss cleared; prescaler cleared.
  - Any tick due in an edit cycle is discarded.
  - Simultaneous hr and min edges apply both.
- Edits with sel==k (1..N_ALARMS): same increments on alarm k-1 hh/mm. Clock time is untouched and keeps running.
- sel > N_ALARMS: edits ignored; display shows the clock.
- disp_time: clock time when sel==0; alarm k-1 with ss=0 when sel==k. One-cycle latency from sel or value change.
- Match rule: evaluated only on a sec_tick whose new time is hh:mm:00 and equals an enabled alarm. Manual edits never cause a match. With multiple matches, the lowest index wins.
- FSM states: IDLE, RINGING, SNOOZED.
  - IDLE→RINGING on match: latch alarm_id, clear ring counter. alarm=1 from the cycle after the matching tick.
  - RINGING: ring counter increments per sec_tick. After RING_SECS ticks → IDLE.
  - RINGING, snooze edge → SNOOZED: countdown loaded with SNOOZE_MIN*60.
  - SNOOZED: countdown decrements per sec_tick; reaching 0 → RINGING with ring counter cleared.
  - A new match while RINGING is ignored. A new match while SNOOZED → RINGING with the new id.
  - alarm_en[alarm_id]=0 in RINGING or SNOOZED → IDLE next cycle (cancel has priority over snooze and timeout).
  - Snooze edge in IDLE or SNOOZED is ignored.
- Reset asserted mid-ring: immediate return to reset values on the next edge.

Optional Feature:
ALARM_AUTOSNOOZE_EN
- Defined: RINGING timeout goes to SNOOZED instead of IDLE. This repeats indefinitely until cancelled via alarm_en.
- Undefined: timeout → IDLE.

Decomposition:
- Package alarm_clk_pkg holds:
  - typedef time_t: packed struct {hh 5b, mm 6b, ss 6b}.
  - typedef ring_state_t: enum IDLE/RINGING/SNOOZED.
  - Constants MAX_HH=23, MAX_MM=59, MAX_SS=59.
- One sub-module, tick_gen: the prescaler producing sec_tick, with a synchronous clear input.

Test Plan:
All scenarios use CLK_FREQ=10, N_ALARMS=2, RING_SECS=3, SNOOZE_MIN=1.
1. Reset, run 10 cycles → one sec_tick pulse; disp_time = 00:00:01.
2. sel=0: 23 inc_hr and 59 inc_min edges, then 59 ticks → 23:59:59; next tick → 00:00:00.
3. sel=1: set alarm0 = 00:01, alarm_en=01, sel=0 at 00:00:00. After 60 ticks → alarm=1, alarm_id=0 one cycle after the tick; alarm=0 after 3 more ticks (undefined macro).
4. Snooze edge while ringing → alarm=0 for 60 ticks, then alarm=1 again. Define ALARM_AUTOSNOOZE_EN and repeat: after 3 ring ticks → SNOOZED instead of IDLE.
5. Both alarms = 00:01, alarm_en=11 → alarm_id=0. Drop alarm_en[0] → alarm=0 next cycle; alarm1 does not ring.
6. sel=3 with inc_min edges → no register changes; disp_time shows the clock.
